executor_movimento: RTL
=======================

// Module: executor_movimento
// PURPOSE
//  Actuator-side counterpart of the wall-following sensor controller: consumes its
//  avancar/girar/remover command levels and executes them as timed motor/shovel
//  sequences. Drives both wheel motors and the debris shovel, tracks the robot's
//  grid position and heading, and reports busy/done back to the controller.
// PARAMETERS
//  STEP_CYCLES   8  cycles motors run forward for one grid step (>=1)
//  TURN_CYCLES   4  cycles motors run for one 90-degree rotation (>=1)
//  REMOVE_CYCLES 6  cycles shovel is active for one removal (>=1)
//  COORD_W       4  width of pos_x/pos_y; coordinates wrap modulo 2**COORD_W
// PORTS
//  clockc2       in   1        system clock, all logic on rising edge
//  reset         in   1        synchronous, active-high reset
//  avancar       in   1        command: advance one step
//  girar         in   1        command: rotate (see BEHAVIOUR for combos)
//  remover       in   1        command: run shovel removal
//  parar         in   1        abort current action
//  motor_esq_en  out  1        left wheel motor enable
//  motor_esq_rev out  1        left wheel reverse (valid when en=1)
//  motor_dir_en  out  1        right wheel motor enable
//  motor_dir_rev out  1        right wheel reverse (valid when en=1)
//  pa_ativa      out  1        shovel active
//  busy          out  1        action in progress, commands ignored
//  done          out  1        1-cycle pulse: action completed normally
//  pos_x, pos_y  out  COORD_W  grid position
//  direcao       out  2        heading: 0=N 1=E 2=S 3=W
//  removidos     out  8        count of completed removals, saturates at 255
// BEHAVIOUR
//  - Reset (sync, any state): state IDLE; all motor/shovel outputs 0; busy=0, done=0;
//    pos=(0,0); direcao=0; removidos=0. Reset overrides parar and commands.
//  - States: IDLE, GIRA_H (clockwise), GIRA_AH (counter-clockwise), AVANCA, REMOVE.
//  - Commands are levels sampled only in IDLE with parar=0. Decode, priority order:
//    remover=1 -> REMOVE; {avancar,girar}=11 -> GIRA_AH then AVANCA (compound);
//    girar=1 -> GIRA_H; avancar=1 -> AVANCA; none -> stay IDLE.
//  - Command sampled at edge N: action state entered at N+1; outputs are registered
//    and asserted from cycle N+1 for exactly the state's cycle count; busy=1 over the
//    same span (compound: TURN_CYCLES+STEP_CYCLES contiguous, busy never drops).
//  - Motor encoding: AVANCA esq_en=dir_en=1, rev=0. GIRA_H esq fwd, dir rev.
//    GIRA_AH esq rev, dir fwd. REMOVE motors off, pa_ativa=1. IDLE all 0.
//  - Down-counter loaded with count-1 on entry; on final cycle of a state the
//    position/heading update is registered: GIRA_H direcao+1 mod 4; GIRA_AH direcao-1
//    mod 4; AVANCA N:y+1 E:x+1 S:y-1 W:x-1, mod 2**COORD_W (wrap, no flag);
//    REMOVE removidos+1 unless already 255.
//  - Compound: heading updated at end of GIRA_AH, AVANCA uses the new heading.
//  - Completion: cycle after final action cycle is IDLE with done=1, busy=0, updated
//    pos/direcao visible; commands sampled in that same cycle are accepted
//    (back-to-back actions: one idle/done cycle between them).
//  - parar=1 while busy: next cycle IDLE, all outputs 0, no done, no position/heading/
//    counter update for the aborted state (a completed turn of a compound is kept).
//    parar=1 in IDLE blocks acceptance. parar on a final cycle wins: no update.
// TESTING
//  1 reset, avancar=1 1 cycle -> busy & both motors fwd 8 cycles, then done=1, pos_y=1
//  2 direcao=0, girar=1 x4 commands -> direcao 1,2,3,0; each 4 cycles esq fwd/dir rev
//  3 avancar=girar=1 at (0,0) heading N -> 4 cyc CCW + 8 cyc fwd, busy 12, pos_x=15
//  4 remover=avancar=girar=1 -> REMOVE only: pa_ativa 6 cycles, removidos=1, pos same
//  5 parar at cycle 3 of AVANCA -> outputs 0 next cycle, no done, pos unchanged
//  6 reset mid-REMOVE after 255 removals -> all outputs 0, removidos=0, pos=(0,0)

Source files
------------

// File: rtl/executor_movimento.sv
// executor_movimento
//   Actuator-side executor for the wall-following controller. It takes the
//   avancar/girar/remover command levels and turns them into timed motor and
//   shovel sequences. It also tracks the robot's grid position and heading,
//   and reports busy/done back to the controller.
//
// Ports
//   clockc2        : system clock, rising edge
//   reset          : synchronous, active-high
//   avancar        : command, advance one grid step
//   girar          : command, rotate (with avancar: CCW turn then step)
//   remover        : command, run one shovel removal (highest priority)
//   parar          : abort the current action / block acceptance in IDLE
//   motor_esq_en   : left wheel enable
//   motor_esq_rev  : left wheel reverse
//   motor_dir_en   : right wheel enable
//   motor_dir_rev  : right wheel reverse
//   pa_ativa       : shovel active
//   busy           : action in progress, commands ignored
//   done           : one-cycle pulse after a normally completed action
//   pos_x, pos_y   : grid position, wraps modulo 2**COORD_W
//   direcao        : heading, 0=N 1=E 2=S 3=W
//   removidos      : completed removals, saturates at 255
module executor_movimento #(
  parameter int unsigned STEP_CYCLES   = 8,
  parameter int unsigned TURN_CYCLES   = 4,
  parameter int unsigned REMOVE_CYCLES = 6,
  parameter int unsigned COORD_W       = 4
) (
  input  logic               clockc2,
  input  logic               reset,
  input  logic               avancar,
  input  logic               girar,
  input  logic               remover,
  input  logic               parar,
  output logic               motor_esq_en,
  output logic               motor_esq_rev,
  output logic               motor_dir_en,
  output logic               motor_dir_rev,
  output logic               pa_ativa,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         direcao,
  output logic [7:0]         removidos
);

  localparam int unsigned MAX_A = (STEP_CYCLES > TURN_CYCLES) ? STEP_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > REMOVE_CYCLES) ? MAX_A : REMOVE_CYCLES;
  localparam int unsigned CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] REMOVE_LOAD = CNT_W'(REMOVE_CYCLES - 1);
  localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GIRA_H  = 3'd1,
    GIRA_AH = 3'd2,
    AVANCA  = 3'd3,
    REMOVE  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               compound, compound_n;
  logic               done_n;
  logic [COORD_W-1:0] x_n, y_n;
  logic [1:0]         dir_n;
  logic [7:0]         rem_n;

  always_ff @(posedge clockc2) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      compound  <= 1'b0;
      done      <= 1'b0;
      pos_x     <= '0;
      pos_y     <= '0;
      direcao   <= '0;
      removidos <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      compound  <= compound_n;
      done      <= done_n;
      pos_x     <= x_n;
      pos_y     <= y_n;
      direcao   <= dir_n;
      removidos <= rem_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    compound_n = compound;
    done_n     = 1'b0;
    x_n        = pos_x;
    y_n        = pos_y;
    dir_n      = direcao;
    rem_n      = removidos;

    if (state == IDLE) begin
      compound_n = 1'b0;
      if (!parar) begin
        if (remover) begin
          state_n = REMOVE;
          cnt_n   = REMOVE_LOAD;
        end else if (avancar && girar) begin
          state_n    = GIRA_AH;
          cnt_n      = TURN_LOAD;
          compound_n = 1'b1;
        end else if (girar) begin
          state_n = GIRA_H;
          cnt_n   = TURN_LOAD;
        end else if (avancar) begin
          state_n = AVANCA;
          cnt_n   = STEP_LOAD;
        end
      end
    end else if (parar) begin
      // Abort discards the current state's update, including on its final cycle.
      state_n    = IDLE;
      compound_n = 1'b0;
    end else if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      state_n = IDLE;
      done_n  = 1'b1;
      unique case (state)
        GIRA_H:  dir_n = direcao + 2'd1;
        GIRA_AH: begin
          dir_n = direcao - 2'd1;
          // The compound step runs straight on; it sees the new heading
          // because the heading register updates on this same edge.
          if (compound) begin
            state_n    = AVANCA;
            cnt_n      = STEP_LOAD;
            compound_n = 1'b0;
            done_n     = 1'b0;
          end
        end
        AVANCA: begin
          unique case (direcao)
            2'd0: y_n = pos_y + C_ONE;
            2'd1: x_n = pos_x + C_ONE;
            2'd2: y_n = pos_y - C_ONE;
            default: x_n = pos_x - C_ONE;
          endcase
        end
        REMOVE:  if (removidos != 8'hFF) rem_n = removidos + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    motor_esq_en  = 1'b0;
    motor_esq_rev = 1'b0;
    motor_dir_en  = 1'b0;
    motor_dir_rev = 1'b0;
    pa_ativa      = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      AVANCA: begin
        motor_esq_en = 1'b1;
        motor_dir_en = 1'b1;
      end
      GIRA_H: begin
        motor_esq_en  = 1'b1;
        motor_dir_en  = 1'b1;
        motor_dir_rev = 1'b1;
      end
      GIRA_AH: begin
        motor_esq_en  = 1'b1;
        motor_esq_rev = 1'b1;
        motor_dir_en  = 1'b1;
      end
      REMOVE:  pa_ativa = 1'b1;
      default: ;
    endcase
  end

endmodule
